// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: ALU_control opcodes, EX state encoding and datapath defaults.
package mips_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;
    localparam int DEF_RAW   = 5;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        EX_IDLE  = 2'd0,
        EX_SHIFT = 2'd1,
        EX_WAIT  = 2'd2
    } ex_state_t;

    function automatic logic isShiftOp(input logic [2:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; the stage is the slave, its upstream/downstream driver the master.
interface ex_alu_stage_if #(
    parameter int WIDTH = mips_pkg::DEF_WIDTH,
    parameter int SHW   = mips_pkg::DEF_SHW,
    parameter int RAW   = mips_pkg::DEF_RAW
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   shamt;
    logic [RAW-1:0]   rd_in;
    logic             reg_write_in;
    logic             flush;
    logic             out_stall;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [RAW-1:0]   rd_out;
    logic             reg_write_out;
    logic             busy;

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, shamt, rd_in, reg_write_in, flush, out_stall,
        output in_ready, out_valid, result, zero, rd_out, reg_write_out, busy
    );

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, shamt, rd_in, reg_write_in, flush, out_stall,
        input  in_ready, out_valid, result, zero, rd_out, reg_write_out, busy
    );

endinterface

// File: rtl/ex_alu_stage_serial_shifter.sv
// One-bit-per-cycle shifter owning the shift counter and work register; done flags the final step.
module serial_shifter
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_dir,
    input  logic [SHW-1:0]   i_cnt,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_work,
    output logic [WIDTH-1:0] o_workNext,
    output logic             o_done
);

    logic             r_dir;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_work;

    // r_dir high means logical right shift (SRL)
    assign o_work     = r_work;
    assign o_workNext = r_dir ? (r_work >> 1) : (r_work << 1);
    assign o_done     = (r_cnt == SHW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir  <= 1'b0;
            r_cnt  <= '0;
            r_work <= '0;
        end else if (i_load) begin
            r_dir  <= i_dir;
            r_cnt  <= i_cnt;
            r_work <= i_data;
        end else if (i_step) begin
            r_cnt  <= r_cnt - SHW'(1);
            r_work <= o_workNext;
        end
    end

endmodule

// File: rtl/ex_alu_stage.sv
// EX-stage execute unit: single-cycle logic/arith ops, serial SLL/SRL with back-pressure,
// and a registered EX/MEM result that honours MEM stalls and pipeline flushes.
module ex_alu_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW,
    parameter int RAW   = DEF_RAW
) (
    input  logic          clk,
    input  logic          reset,
    ex_alu_stage_if.slave io_ex
);

    ex_state_t        r_state;
    ex_state_t        w_nextState;
    logic             w_accept;
    logic             w_isShift;
    logic             w_slt;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_shLoad;
    logic             w_shStep;
    logic             w_shDone;
    logic [WIDTH-1:0] w_shWork;
    logic [WIDTH-1:0] w_shWorkNext;
    logic             w_outLoad;
    logic [WIDTH-1:0] w_outData;
    logic [RAW-1:0]   w_outRd;
    logic             w_outRegWrite;
    logic [RAW-1:0]   r_shRd;
    logic             r_shRegWrite;
    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [RAW-1:0]   r_rd;
    logic             r_regWrite;

    assign io_ex.in_ready      = (r_state == EX_IDLE) && !io_ex.out_stall;
    assign io_ex.busy          = (r_state != EX_IDLE);
    assign io_ex.out_valid     = r_outValid;
    assign io_ex.result        = r_result;
    assign io_ex.zero          = r_zero;
    assign io_ex.rd_out        = r_rd;
    assign io_ex.reg_write_out = r_regWrite && r_outValid;

    assign w_accept  = io_ex.in_valid && io_ex.in_ready;
    assign w_isShift = isShiftOp(io_ex.alu_ctrl);
    assign w_diff    = io_ex.op_a - io_ex.op_b;
    // Signed less-than from the subtraction; when signs differ the difference may overflow
    assign w_slt     = (io_ex.op_a[WIDTH-1] ^ io_ex.op_b[WIDTH-1]) ? io_ex.op_a[WIDTH-1]
                                                                    : w_diff[WIDTH-1];

    always_comb begin
        w_aluResult = io_ex.op_b;
        case (io_ex.alu_ctrl)
            ALU_AND:  w_aluResult = io_ex.op_a & io_ex.op_b;
            ALU_OR:   w_aluResult = io_ex.op_a | io_ex.op_b;
            ALU_ADD:  w_aluResult = io_ex.op_a + io_ex.op_b;
            ALU_SUB:  w_aluResult = w_diff;
            ALU_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (io_ex.op_a < io_ex.op_b)};
            default:  w_aluResult = io_ex.op_b;
        endcase
    end

    serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_shLoad),
        .i_step     (w_shStep),
        .i_dir      (io_ex.alu_ctrl == ALU_SRL),
        .i_cnt      (io_ex.shamt),
        .i_data     (io_ex.op_b),
        .o_work     (w_shWork),
        .o_workNext (w_shWorkNext),
        .o_done     (w_shDone)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_shLoad      = 1'b0;
        w_shStep      = 1'b0;
        w_outLoad     = 1'b0;
        w_outData     = w_aluResult;
        w_outRd       = io_ex.rd_in;
        w_outRegWrite = io_ex.reg_write_in;
        case (r_state)
            EX_IDLE: begin
                if (w_accept) begin
                    if (w_isShift && (io_ex.shamt != '0)) begin
                        w_shLoad    = 1'b1;
                        w_nextState = EX_SHIFT;
                    end else begin
                        w_outLoad = 1'b1;
                    end
                end
            end
            EX_SHIFT: begin
                w_shStep      = 1'b1;
                w_outData     = w_shWorkNext;
                w_outRd       = r_shRd;
                w_outRegWrite = r_shRegWrite;
                if (w_shDone) begin
                    if (io_ex.out_stall) begin
                        w_nextState = EX_WAIT;
                    end else begin
                        w_outLoad   = 1'b1;
                        w_nextState = EX_IDLE;
                    end
                end
            end
            EX_WAIT: begin
                w_outData     = w_shWork;
                w_outRd       = r_shRd;
                w_outRegWrite = r_shRegWrite;
                if (!io_ex.out_stall) begin
                    w_outLoad   = 1'b1;
                    w_nextState = EX_IDLE;
                end
            end
            default: w_nextState = EX_IDLE;
        endcase
        // A flush drops whatever would have been accepted or completed this edge
        if (io_ex.flush) begin
            w_nextState = EX_IDLE;
            w_shLoad    = 1'b0;
            w_outLoad   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shRd       <= '0;
            r_shRegWrite <= 1'b0;
        end else if (w_shLoad) begin
            r_shRd       <= io_ex.rd_in;
            r_shRegWrite <= io_ex.reg_write_in;
        end
    end

    // EX/MEM register: flush clears validity even while MEM is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_rd       <= '0;
            r_regWrite <= 1'b0;
        end else if (io_ex.flush) begin
            r_outValid <= 1'b0;
            r_regWrite <= 1'b0;
        end else if (!io_ex.out_stall) begin
            if (w_outLoad) begin
                r_outValid <= 1'b1;
                r_result   <= w_outData;
                r_zero     <= (w_outData == '0);
                r_rd       <= w_outRd;
                r_regWrite <= w_outRegWrite;
            end else begin
                r_outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed corner cases plus randomized traffic,
// all compared every cycle against a countdown-based behavioural model of the stage.
module tb_ex_alu_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    bit   checkEn = 1'b0;
    int   nChecks = 0;
    int   nPassed = 0;

    ex_alu_stage_if bus ();

    ex_alu_stage dut (
        .clk   (clk),
        .reset (reset),
        .io_ex (bus)
    );

    always #5 clk = ~clk;

    // Model state: an in-flight shift is a precomputed result plus edges left before it may emit
    bit          mPending = 1'b0;
    int          mRemain  = 0;
    logic [31:0] mPendRes = '0;
    logic [4:0]  mPendRd  = '0;
    logic        mPendRw  = 1'b0;
    logic        mValid   = 1'b0;
    logic [31:0] mResult  = '0;
    logic        mZero    = 1'b1;
    logic [4:0]  mRd      = '0;
    logic        mRw      = 1'b0;
    bit          mProduce;
    bit          mAccept;
    logic [31:0] mNewRes;
    logic [4:0]  mNewRd;
    logic        mNewRw;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [2:0] ctrl, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (ctrl)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return b << sh;
            default:  return b >> sh;
        endcase
    endfunction

    always @(posedge clk) begin
        mProduce = 1'b0;
        mNewRes  = '0;
        mNewRd   = '0;
        mNewRw   = 1'b0;
        mAccept  = bus.in_valid && !mPending && !bus.out_stall;
        if (reset) begin
            mPending = 1'b0;
            mRemain  = 0;
            mValid   = 1'b0;
            mResult  = '0;
            mZero    = 1'b1;
            mRd      = '0;
            mRw      = 1'b0;
        end else if (bus.flush) begin
            mPending = 1'b0;
            mRemain  = 0;
            mValid   = 1'b0;
            mRw      = 1'b0;
        end else begin
            if (mPending) begin
                if (mRemain <= 1 && !bus.out_stall) begin
                    mProduce = 1'b1;
                    mNewRes  = mPendRes;
                    mNewRd   = mPendRd;
                    mNewRw   = mPendRw;
                    mPending = 1'b0;
                end
                if (mRemain > 0) mRemain--;
            end else if (mAccept) begin
                if ((bus.alu_ctrl == ALU_SLL || bus.alu_ctrl == ALU_SRL) && bus.shamt != 5'd0) begin
                    mPending = 1'b1;
                    mRemain  = int'(bus.shamt);
                    mPendRes = refAlu(bus.alu_ctrl, bus.op_a, bus.op_b, bus.shamt);
                    mPendRd  = bus.rd_in;
                    mPendRw  = bus.reg_write_in;
                end else begin
                    mProduce = 1'b1;
                    mNewRes  = refAlu(bus.alu_ctrl, bus.op_a, bus.op_b, bus.shamt);
                    mNewRd   = bus.rd_in;
                    mNewRw   = bus.reg_write_in;
                end
            end
            if (!bus.out_stall) begin
                if (mProduce) begin
                    mValid  = 1'b1;
                    mResult = mNewRes;
                    mZero   = (mNewRes == 32'd0);
                    mRd     = mNewRd;
                    mRw     = mNewRw;
                end else begin
                    mValid = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled just after the inputs change at negedge
    always begin
        @(negedge clk);
        #2;
        if (checkEn) begin
            checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
            checkOutput("result", bus.result, mResult);
            checkOutput("zero", 32'(bus.zero), 32'(mZero));
            checkOutput("rd_out", 32'(bus.rd_out), 32'(mRd));
            checkOutput("reg_write_out", 32'(bus.reg_write_out), 32'(mValid && mRw));
            checkOutput("busy", 32'(bus.busy), 32'(mPending));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(!mPending && !bus.out_stall));
        end
    end

    task automatic applyStimulus(input logic v, input logic [2:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh, input logic [4:0] rd,
                                 input logic rw, input logic st, input logic fl, input logic rs);
        @(negedge clk);
        bus.in_valid     = v;
        bus.alu_ctrl     = ctrl;
        bus.op_a         = a;
        bus.op_b         = b;
        bus.shamt        = sh;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
        bus.out_stall    = st;
        bus.flush        = fl;
        reset            = rs;
    endtask

    task automatic idleStim(input logic st, input logic fl, input logic rs);
        applyStimulus(1'b0, ALU_AND, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, st, fl, rs);
    endtask

    task automatic waitResult(output int k);
        k = 0;
        while (!bus.out_valid && k < 40) begin
            idleStim(1'b0, 1'b0, 1'b0);
            k++;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_result"}, bus.result, 32'h0);
        checkOutput({tag, "_zero"}, 32'(bus.zero), 32'd1);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_rd"}, 32'(bus.rd_out), 32'd0);
        checkOutput({tag, "_rw"}, 32'(bus.reg_write_out), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] pickShamt();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        int k;
        bus.in_valid     = 1'b0;
        bus.alu_ctrl     = ALU_AND;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.shamt        = '0;
        bus.rd_in        = '0;
        bus.reg_write_in = 1'b0;
        bus.out_stall    = 1'b0;
        bus.flush        = 1'b0;
        reset            = 1'b1;
        repeat (2) idleStim(1'b0, 1'b0, 1'b1);
        idleStim(1'b0, 1'b0, 1'b0);
        checkEn = 1'b1;
        checkResetState("reset");

        $display("[TB] ADD wrap");
        applyStimulus(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("add_result", bus.result, 32'h8000_0000);
        checkOutput("add_zero", 32'(bus.zero), 32'd0);
        checkOutput("add_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("add_rw", 32'(bus.reg_write_out), 32'd1);
        idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("add_valid_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("add_hold", bus.result, 32'h8000_0000);

        $display("[TB] SUB / SLT / SLTU");
        applyStimulus(1'b1, ALU_SUB, 32'd5, 32'd5, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sub_result", bus.result, 32'h0);
        checkOutput("sub_zero", 32'(bus.zero), 32'd1);
        applyStimulus(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("slt_result", bus.result, 32'h1);
        idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("sltu_result", bus.result, 32'h0);

        $display("[TB] SLL by 31");
        applyStimulus(1'b1, ALU_SLL, 32'h0, 32'h1, 5'd31, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("sll_busy", 32'(bus.busy), 32'd1);
        checkOutput("sll_in_ready", 32'(bus.in_ready), 32'd0);
        waitResult(k);
        checkOutput("sll_latency", 32'(k), 32'd31);
        checkOutput("sll_result", bus.result, 32'h8000_0000);
        checkOutput("sll_rd", 32'(bus.rd_out), 32'd7);
        checkOutput("sll_in_ready_back", 32'(bus.in_ready), 32'd1);

        $display("[TB] SRL by 4");
        applyStimulus(1'b1, ALU_SRL, 32'h0, 32'h8000_0000, 5'd4, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        waitResult(k);
        checkOutput("srl_latency", 32'(k), 32'd4);
        checkOutput("srl_result", bus.result, 32'h0800_0000);

        $display("[TB] SRL with MEM stall");
        applyStimulus(1'b1, ALU_SRL, 32'h0, 32'hF000_0000, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        repeat (5) idleStim(1'b1, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("stall_busy", 32'(bus.busy), 32'd1);
        checkOutput("stall_frozen_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("stall_frozen_result", bus.result, 32'h0800_0000);
        idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_result", bus.result, 32'h1E00_0000);
        checkOutput("stall_rd", 32'(bus.rd_out), 32'd9);

        $display("[TB] flush mid-shift");
        applyStimulus(1'b1, ALU_SLL, 32'h0, 32'h3, 5'd10, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b1, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("flush_busy", 32'(bus.busy), 32'd0);
        checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_rw", 32'(bus.reg_write_out), 32'd0);
        applyStimulus(1'b1, ALU_ADD, 32'd3, 32'd4, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("post_flush_result", bus.result, 32'd7);
        checkOutput("post_flush_rd", 32'(bus.rd_out), 32'd6);
        checkOutput("post_flush_rw", 32'(bus.reg_write_out), 32'd1);
        repeat (12) idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("flush_no_stray", 32'(bus.out_valid), 32'd0);

        $display("[TB] reset mid-shift and mid-stall");
        applyStimulus(1'b1, ALU_ADD, 32'd10, 32'd20, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ALU_SLL, 32'h0, 32'h1, 5'd20, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_result", bus.result, 32'd30);
        repeat (2) idleStim(1'b0, 1'b0, 1'b0);
        idleStim(1'b0, 1'b0, 1'b1);
        idleStim(1'b0, 1'b0, 1'b0);
        checkResetState("rst_shift");
        repeat (25) idleStim(1'b0, 1'b0, 1'b0);
        checkOutput("rst_no_result", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idleStim(1'b1, 1'b0, 1'b0);
        checkOutput("pre_reset2_valid", 32'(bus.out_valid), 32'd1);
        idleStim(1'b1, 1'b0, 1'b1);
        idleStim(1'b0, 1'b0, 1'b0);
        checkResetState("rst_stall");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pickOperand(),
                          pickOperand(), pickShamt(), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
        end
        repeat (40) idleStim(1'b0, 1'b0, 1'b0);
        checkEn = 1'b0;
        #3;
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
